// File: rtl/rv_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package rv_pkg;

  localparam int NREG      = 32;
  localparam int LAT_W     = 3;
  localparam int AGE_W     = 3;
  localparam int FLUSH_AGE = 2;

  typedef logic [$clog2(NREG)-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0]        lat_t;
  typedef logic [AGE_W-1:0]        age_t;

  typedef struct packed {
    logic busy;
    lat_t cnt;
    age_t age;
  } sb_entry_t;

  localparam lat_t LAT_ALU  = 3'd1;
  localparam lat_t LAT_LOAD = 3'd2;
  localparam lat_t LAT_MUL  = 3'd4;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: pending-write flag, cycles-to-forwardable and producer age.
module sb_entry
  import rv_pkg::*;
#(
  parameter int LAT_W     = rv_pkg::LAT_W,
  parameter int AGE_W     = rv_pkg::AGE_W,
  parameter int FLUSH_AGE = rv_pkg::FLUSH_AGE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic [LAT_W-1:0] alloc_lat,
  input  logic             wb,
  input  logic             flush,
  output logic             busy,
  output logic             ready,
  output logic [LAT_W-1:0] cnt,
  output logic [AGE_W-1:0] age
);

  localparam logic [AGE_W-1:0] AGE_MAX     = '1;
  localparam logic [AGE_W-1:0] FLUSH_AGE_V = AGE_W'(FLUSH_AGE);

  logic             busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q,  cnt_d;
  logic [AGE_W-1:0] age_q,  age_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    age_d  = age_q;
    if (busy_q) begin
      if (cnt_q != '0)     cnt_d = cnt_q - LAT_W'(1);
      if (age_q != AGE_MAX) age_d = age_q + AGE_W'(1);
    end
    // A producer still counting down belongs to a newer issue than the write-back.
    if (flush && busy_q && (age_q < FLUSH_AGE_V)) busy_d = 1'b0;
    else if (wb && (cnt_q == '0))                  busy_d = 1'b0;
    // Stored values already include the issue-cycle tick: one cycle has elapsed when read.
    if (alloc) begin
      busy_d = 1'b1;
      cnt_d  = (alloc_lat == '0) ? '0 : alloc_lat - LAT_W'(1);
      age_d  = AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      age_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

  assign busy  = busy_q;
  assign ready = busy_q && (cnt_q == '0);
  assign cnt   = cnt_q;
  assign age   = age_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: RAW/WAW stall, bypass select and flush of young producers.
module hazard_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG      = rv_pkg::NREG,
  parameter int LAT_W     = rv_pkg::LAT_W,
  parameter int AGE_W     = rv_pkg::AGE_W,
  parameter int FLUSH_AGE = rv_pkg::FLUSH_AGE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] issue_rs1,
  input  logic [$clog2(NREG)-1:0] issue_rs2,
  input  logic                    issue_rs1_en,
  input  logic                    issue_rs2_en,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  input  logic                    issue_rd_en,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic                    flush,
  output logic                    issue_stall,
  output logic                    issue_ack,
  output logic                    fwd1_valid,
  output logic [AGE_W-1:0]        fwd1_age,
  output logic                    fwd2_valid,
  output logic [AGE_W-1:0]        fwd2_age
);

  localparam int IDX_W = $clog2(NREG);

  logic [NREG-1:0]            busy_v;
  logic [NREG-1:0]            ready_v;
  logic [NREG-1:0][LAT_W-1:0] cnt_v;
  logic [NREG-1:0][AGE_W-1:0] age_v;

  logic alloc_en;
  assign alloc_en = issue_ack && issue_rd_en && (issue_rd != '0);

  // x0 has no slot; its views are tied idle so the read muxes stay uniform.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_ent
    if (gi == 0) begin : g_x0
      assign busy_v[gi]  = 1'b0;
      assign ready_v[gi] = 1'b0;
      assign cnt_v[gi]   = '0;
      assign age_v[gi]   = '0;
    end else begin : g_reg
      logic alloc_hit, wb_hit;
      assign alloc_hit = alloc_en && (issue_rd == IDX_W'(gi));
      assign wb_hit    = wb_valid && (wb_rd == IDX_W'(gi));
      sb_entry #(
        .LAT_W     (LAT_W),
        .AGE_W     (AGE_W),
        .FLUSH_AGE (FLUSH_AGE)
      ) u_ent (
        .clk       (clk),
        .rst       (rst),
        .alloc     (alloc_hit),
        .alloc_lat (issue_lat),
        .wb        (wb_hit),
        .flush     (flush),
        .busy      (busy_v[gi]),
        .ready     (ready_v[gi]),
        .cnt       (cnt_v[gi]),
        .age       (age_v[gi])
      );
    end
  end

  logic src1_busy, src2_busy, raw1, raw2, waw;

  always_comb begin
    src1_busy   = issue_rs1_en && (issue_rs1 != '0) && busy_v[issue_rs1];
    src2_busy   = issue_rs2_en && (issue_rs2 != '0) && busy_v[issue_rs2];
    raw1        = src1_busy && !ready_v[issue_rs1];
    raw2        = src2_busy && !ready_v[issue_rs2];
    // A shorter-latency write must not land before an older, slower one to the same rd.
    waw         = issue_rd_en && (issue_rd != '0) && busy_v[issue_rd] &&
                  (cnt_v[issue_rd] > issue_lat);
    issue_stall = issue_valid && (raw1 || raw2 || waw);
    issue_ack   = issue_valid && !issue_stall && !flush;
    fwd1_valid  = src1_busy && ready_v[issue_rs1] && !issue_stall;
    fwd2_valid  = src2_busy && ready_v[issue_rs2] && !issue_stall;
    fwd1_age    = fwd1_valid ? age_v[issue_rs1] : '0;
    fwd2_age    = fwd2_valid ? age_v[issue_rs2] : '0;
  end

endmodule
